// File: rtl/piso_shift_tx_pkg.sv
// Shared types and constants for the PISO shift transmitter.
// State encodings and direction constants are common to the shift datapath blocks.
package piso_shift_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;  // MSB first
  localparam logic DIR_RIGHT = 1'b1;  // LSB first

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle of the PISO shift transmitter.
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_valid, din, dir,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_valid, din, dir,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_shift_tx_shift_step.sv
// One-bit zero-fill shift of a WIDTH-bit word, left or right by dir.
module piso_shift_tx_shift_step
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  output logic [WIDTH-1:0] word_nxt
);

  always_comb begin
    if (dir == DIR_RIGHT) word_nxt = {1'b0, word[WIDTH-1:1]};
    else                  word_nxt = {word[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter: one WIDTH-bit word per handshake, one bit per clk.
// Define PARITY_EN to append an even-parity bit after each word.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  piso_shift_tx_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_step;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;
  logic             load_ready_c, ser_out_c, ser_valid_c, ser_last_c, busy_c;

  piso_shift_tx_shift_step #(.WIDTH(WIDTH)) u_step (
    .word     (shreg),
    .dir      (dir_q),
    .word_nxt (shreg_step)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = bus.load_valid && load_ready_c;

`ifdef PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^bus.din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Word is captured whole at acceptance, so din changes in flight cannot reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      dir_q <= DIR_LEFT;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= bus.din;
      dir_q <= bus.dir;
      cnt   <= '0;
    end else if (state == ST_SHIFT) begin
      shreg <= shreg_step;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    load_ready_c = 1'b0;
    ser_out_c    = 1'b0;
    ser_valid_c  = 1'b0;
    ser_last_c   = 1'b0;
    busy_c       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        load_ready_c = !rst;
        if (bus.load_valid && !rst) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid_c = 1'b1;
        ser_out_c   = (dir_q == DIR_RIGHT) ? shreg[0] : shreg[WIDTH-1];
        if (last_bit) begin
`ifdef PARITY_EN
          state_nxt  = ST_PARITY;
`else
          ser_last_c = 1'b1;
          state_nxt  = ST_IDLE;
`endif
        end
      end
      ST_PARITY: begin
`ifdef PARITY_EN
        ser_valid_c = 1'b1;
        ser_out_c   = par_q;
        ser_last_c  = 1'b1;
`endif
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.load_ready = load_ready_c;
  assign bus.ser_out    = ser_out_c;
  assign bus.ser_valid  = ser_valid_c;
  assign bus.ser_last   = ser_last_c;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx at WIDTH=4: table of words plus hand sequences.
module tb_piso_shift_tx;

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  typedef struct {
    logic [3:0] din;
    logic       dir;
    logic [3:0] seq;   // bits in send order, seq[3] first
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   prev_last = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[8];

  piso_shift_tx_if #(.WIDTH(4)) bus ();

  piso_shift_tx #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_last) check("gap_after_last", bus.ser_valid, 1'b0);
      if (bus.ser_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ser_out", bus.ser_out, e.bit_v);
          check("ser_last", bus.ser_last, e.last);
        end
      end
      prev_last = bus.ser_valid && bus.ser_last;
    end else begin
      prev_last = 1'b0;
    end
  end

  task automatic push_word(input logic [3:0] seq, input logic par);
    for (int k = 0; k < 4; k++) begin
`ifdef PARITY_EN
      exp_q.push_back('{bit_v: seq[3-k], last: 1'b0});
`else
      exp_q.push_back('{bit_v: seq[3-k], last: (k == 3)});
`endif
    end
`ifdef PARITY_EN
    exp_q.push_back('{bit_v: par, last: 1'b1});
`else
    if (par === 1'bx) exp_q.push_back('{bit_v: 1'b0, last: 1'b0});
`endif
  endtask

  task automatic send_word(input logic [3:0] d, input logic dr, input logic [3:0] seq,
                           input logic par, input bit hold);
    int n = 0;
    forever begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.din        = d;
      bus.dir        = dr;
      if (bus.load_ready) break;
      n++;
      if (n > 40) begin
        check("accept_timeout", 1'b0, 1'b1);
        bus.load_valid = 1'b0;
        return;
      end
    end
    push_word(seq, par);
    @(posedge clk);
    #1;
    if (!hold) bus.load_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1'b1);
    check("ready_low_in_shift", bus.load_ready, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || bus.busy) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        check("drain_timeout", 1'b0, 1'b1);
        exp_q.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 4'b0110, dir: 1'b0, seq: 4'b0110, par: 1'b0};
    vecs[1] = '{din: 4'b1110, dir: 1'b1, seq: 4'b0111, par: 1'b1};
    vecs[2] = '{din: 4'b0011, dir: 1'b0, seq: 4'b0011, par: 1'b0};
    vecs[3] = '{din: 4'b1111, dir: 1'b1, seq: 4'b1111, par: 1'b0};
    vecs[4] = '{din: 4'b1000, dir: 1'b1, seq: 4'b0001, par: 1'b1};
    vecs[5] = '{din: 4'b0001, dir: 1'b0, seq: 4'b0001, par: 1'b1};
    vecs[6] = '{din: 4'b1011, dir: 1'b1, seq: 4'b1101, par: 1'b1};
    vecs[7] = '{din: 4'b1110, dir: 1'b0, seq: 4'b1110, par: 1'b1};

    bus.load_valid = 1'b0;
    bus.din        = 4'b0000;
    bus.dir        = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_load_ready", bus.load_ready, 1'b0);
    check("rst_ser_valid", bus.ser_valid, 1'b0);
    check("rst_ser_last", bus.ser_last, 1'b0);
    check("rst_ser_out", bus.ser_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.load_ready, 1'b1);
    mon_en = 1'b1;

    // table of isolated words
    foreach (vecs[i]) begin
      send_word(vecs[i].din, vecs[i].dir, vecs[i].seq, vecs[i].par, 1'b0);
      drain();
      check("idle_ready", bus.load_ready, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
    end

    // back-to-back with load_valid held: second word only taken in the IDLE cycle
    send_word(4'b0011, 1'b0, 4'b0011, 1'b0, 1'b1);
    send_word(4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0);
    drain();

    // din changes while a word is in flight
    send_word(4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0);
    bus.din = 4'b0000;
    bus.dir = 1'b1;
    drain();

    // reset during bit 2 of 0110 (MSB first: 0,1,1,0)
    mon_en = 1'b0;
    send_word(4'b0110, 1'b0, 4'b0110, 1'b0, 1'b0);
    exp_q.delete();
    check("mid_bit0", bus.ser_out, 1'b0);
    @(posedge clk); #1;
    check("mid_bit1", bus.ser_out, 1'b1);
    @(posedge clk); #1;
    check("mid_bit2", bus.ser_out, 1'b1);
    check("mid_bit2_valid", bus.ser_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("ready_low_in_rst", bus.load_ready, 1'b0);
    @(posedge clk); #1;
    check("abort_ser_valid", bus.ser_valid, 1'b0);
    check("abort_ser_last", bus.ser_last, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready_rst", bus.load_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("ready_after_abort", bus.load_ready, 1'b1);
    mon_en = 1'b1;
    send_word(4'b1001, 1'b0, 4'b1001, 1'b0, 1'b0);
    drain();

    check("final_queue_empty", (exp_q.size() == 0), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
